mul_share_ctrl: RTL

- Arbitrates NUM_REQ requesters onto one shared 8x8 unsigned multiplier (the team's `mul_array`).
- Sequences each operation: capture operands, compute, register the result, return it with a tag identifying the requester.
- Sits between requesting engines and the multiplier datapath.
- Round-robin fairness, valid/ready handshakes on both sides.

---
 rtl/mul_share_pkg.sv | 21 ++
 rtl/mul_array.sv | 16 +
 rtl/rr_arbiter.sv | 40 ++++
 rtl/mul_share_ctrl.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/mul_share_pkg.sv
// rtl/mul_share_pkg.sv - shared widths, FSM states and round-robin helper for mul_share_ctrl
package mul_share_pkg;

    localparam int DATA_W = 8;
    localparam int PROD_W = 16;

    // CALC is used by the single-stage build; CALC1/CALC2 by the product-register build
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CALC  = 3'd1,
        CALC1 = 3'd2,
        CALC2 = 3'd3,
        RESP  = 3'd4
    } state_t;

    // Next requester index after cur, wrapping at n
    function automatic int rr_next(input int cur, input int n);
        return (cur + 1 >= n) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/mul_array.sv
// rtl/mul_array.sv - combinational unsigned array multiplier shared by the engines
module mul_array #(
    parameter int A_W = 8,
    parameter int B_W = 8
) (
    input  logic [A_W-1:0]     a,
    input  logic [B_W-1:0]     b,
    output logic [A_W+B_W-1:0] p
);

    // Full-width unsigned product; the result width holds 255*255 without overflow
    always_comb begin
        p = a * b;
    end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, search starts after ptr
module rr_arbiter
    import mul_share_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          found
);

    logic [IW-1:0] cand;

    // Walk the ring from ptr+1 and stop at the first active request
    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = IW'(rr_next(int'(ptr), N));
        for (int k = 0; k < N; k++) begin
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
            cand = IW'(rr_next(int'(cand), N));
        end
    end

    // Grant is only driven when the controller is able to accept
    always_comb begin
        grant = '0;
        if (en && found) begin
            grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/mul_share_ctrl.sv
// rtl/mul_share_ctrl.sv - round-robin sharing of one multiplier; MUL_SHARE_CTRL_OPREG_EN adds a product register
module mul_share_ctrl
    import mul_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [PROD_W-1:0]         rsp_data,
    output logic [ID_W-1:0]           rsp_id,
    output logic                      busy
);

`ifdef MUL_SHARE_CTRL_OPREG_EN
    localparam state_t CALC_FIRST = CALC1;
`else
    localparam state_t CALC_FIRST = CALC;
`endif

    state_t              state;
    state_t              state_nxt;
    logic [ID_W-1:0]     ptr;
    logic                accept_en;
    logic                any_req;
    logic                accept;
    logic [ID_W-1:0]     grant_idx;
    logic [DATA_W-1:0]   sel_a;
    logic [DATA_W-1:0]   sel_b;
    logic [DATA_W-1:0]   op_a;
    logic [DATA_W-1:0]   op_b;
    logic [ID_W-1:0]     op_id;
    logic [PROD_W-1:0]   product;
`ifdef MUL_SHARE_CTRL_OPREG_EN
    logic [PROD_W-1:0]   prod_q;
`endif

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .en    (accept_en),
        .grant (req_ready),
        .idx   (grant_idx),
        .found (any_req)
    );

    mul_array #(
        .A_W (DATA_W),
        .B_W (DATA_W)
    ) u_mul (
        .a (op_a),
        .b (op_b),
        .p (product)
    );

    assign accept = accept_en && any_req;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: a new op can start from IDLE or directly out of a completed response
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = CALC_FIRST;
            CALC:    state_nxt = RESP;
            CALC1:   state_nxt = CALC2;
            CALC2:   state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = accept ? CALC_FIRST : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: accept window and busy flag
    always_comb begin
        accept_en = (state == IDLE) || ((state == RESP) && rsp_ready);
        busy      = (state != IDLE);
    end

    // Mux the winning requester's operands
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                sel_a = req_a[i*DATA_W +: DATA_W];
                sel_b = req_b[i*DATA_W +: DATA_W];
            end
        end
    end

    // Operand capture, RR pointer update and result register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr       <= ID_W'(NUM_REQ - 1);
            op_a      <= '0;
            op_b      <= '0;
            op_id     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
`ifdef MUL_SHARE_CTRL_OPREG_EN
            prod_q    <= '0;
`endif
        end else begin
            if (accept) begin
                op_a  <= sel_a;
                op_b  <= sel_b;
                op_id <= grant_idx;
                ptr   <= grant_idx;
            end
`ifdef MUL_SHARE_CTRL_OPREG_EN
            if (state == CALC1) begin
                prod_q <= product;
            end
            if (state == CALC2) begin
                rsp_data  <= prod_q;
                rsp_id    <= op_id;
                rsp_valid <= 1'b1;
            end
`else
            if (state == CALC) begin
                rsp_data  <= product;
                rsp_id    <= op_id;
                rsp_valid <= 1'b1;
            end
`endif
            if ((state == RESP) && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule
